// File: rtl/mode_sel_fsm_if.sv
// Front-panel button inputs and mode-select outputs of the clock mode selector.
// The master side drives the raw buttons and observes the mode bus.
interface mode_sel_fsm_if;
    logic       btn_mode;
    logic       btn_set;
    logic [4:0] sel_mode;
    logic       mode_chg;

    modport master (output btn_mode, output btn_set, input sel_mode, input mode_chg);
    modport slave  (input btn_mode, input btn_set, output sel_mode, output mode_chg);
endinterface

// File: rtl/mode_sel_fsm.sv
// Purpose: condition MODE/SET buttons (sync, debounce, press/long-press) and run the one-hot operating-mode FSM.
// Latency: raw press steady before edge n -> stable at edge n+1+DEB_CYC, mode update at edge n+2+DEB_CYC.
// Backpressure: none; button inputs are free-running levels and outputs are registered every cycle.
module mode_sel_fsm #(
    parameter logic [19:0] DEB_CYC  = 20'd500000,
    parameter logic [26:0] LONG_CYC = 27'd100000000
) (
    input logic           clk,
    input logic           rst,
    mode_sel_fsm_if.slave bus
);
    localparam logic [4:0] SET_TIME  = 5'b00001;
    localparam logic [4:0] TIME      = 5'b00010;
    localparam logic [4:0] ALARM     = 5'b00100;
    localparam logic [4:0] KITCHEN   = 5'b01000;
    localparam logic [4:0] STOPWATCH = 5'b10000;

    localparam int BM = 0;
    localparam int BS = 1;

    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  stable;
    logic [1:0]  stable_prev;
    logic [1:0]  armed;
    logic [1:0]  fill;
    logic [19:0] deb_cnt [2];
    logic [26:0] hold_cnt;

    logic        mode_press;
    logic        set_long;
    logic        set_short;
    logic [4:0]  mode_q;
    logic [4:0]  next_mode;
    logic        mode_chg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            stable_prev <= '0;
            armed       <= '0;
            fill        <= '0;
            deb_cnt[0]  <= '0;
            deb_cnt[1]  <= '0;
            hold_cnt    <= '0;
        end else begin
            sync1       <= {bus.btn_set, bus.btn_mode};
            sync2       <= sync1;
            stable_prev <= stable;
            fill        <= {fill[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (deb_cnt[i] == DEB_CYC - 20'd1) begin
                        stable[i]  <= ~stable[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 20'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
                // Arm only on a genuine released sample, once the synchroniser
                // holds real post-reset data, so a button held through reset stays locked out.
                if (fill[1] && !stable[i] && !sync2[i]) begin
                    armed[i] <= 1'b1;
                end
            end
            if (!stable[BS]) begin
                hold_cnt <= '0;
            end else if (hold_cnt != LONG_CYC) begin
                hold_cnt <= hold_cnt + 27'd1;
            end
        end
    end

    // hold_cnt saturates at LONG_CYC, so it sits on LONG_CYC-1 for exactly one cycle per hold.
    assign mode_press = armed[BM] && stable[BM] && !stable_prev[BM];
    assign set_long   = armed[BS] && (hold_cnt == LONG_CYC - 27'd1);
    assign set_short  = armed[BS] && !stable[BS] && stable_prev[BS]
                        && (hold_cnt < LONG_CYC - 27'd1);

    always_comb begin
        next_mode = mode_q;
        case (mode_q)
            TIME: begin
                if (set_long) begin
                    next_mode = SET_TIME;
                end else if (mode_press) begin
                    next_mode = ALARM;
                end
            end
            ALARM:     if (mode_press) next_mode = KITCHEN;
            KITCHEN:   if (mode_press) next_mode = STOPWATCH;
            STOPWATCH: if (mode_press) next_mode = TIME;
            SET_TIME:  if (set_short)  next_mode = TIME;
            default:   next_mode = TIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= TIME;
            mode_chg_q <= 1'b0;
        end else begin
            mode_q     <= next_mode;
            mode_chg_q <= (next_mode != mode_q);
        end
    end

    assign bus.sel_mode = mode_q;
    assign bus.mode_chg = mode_chg_q;
endmodule
